// File: rtl/sr_load_ctrl.sv
// sr_load_ctrl: loads a parallel word into an external serial-in shift
// register one bit per cycle, then pulses done_o.
// Optional readback check compiled in with `define SR_LOAD_READBACK_EN.
module sr_load_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_data_i,
    input  logic             abort_i,
    output logic             ser_o,
    output logic             shift_en_o,
    input  logic [WIDTH-1:0] sr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [7:0]       frames_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] img, img_nxt;
    logic [WIDTH-1:0] req_img;
    logic             ser_nxt, shift_en_nxt, busy_nxt, done_nxt;
    logic [7:0]       frames_nxt;

    // The held word is stored in shift-register image order: the bit sent
    // first sits at the top, so it is also the expected readback image.
    for (genvar i = 0; i < WIDTH; i++) begin : g_order
        assign req_img[i] = MSB_FIRST ? req_data_i[i] : req_data_i[WIDTH-1-i];
    end

    assign req_ready_o = rstn && (state == ST_IDLE);

`ifdef SR_LOAD_READBACK_EN
    logic err_nxt;
`else
    logic unused_sr;
    assign unused_sr = ^sr_i;
    assign err_o     = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        img_nxt      = img;
        ser_nxt      = 1'b0;
        shift_en_nxt = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        frames_nxt   = frames_o;
`ifdef SR_LOAD_READBACK_EN
        err_nxt      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    img_nxt      = req_img;
                    cnt_nxt      = '0;
                    state_nxt    = ST_SHIFT;
                    ser_nxt      = req_img[WIDTH-1];
                    shift_en_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort_i) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == LAST) begin
`ifdef SR_LOAD_READBACK_EN
                    state_nxt  = ST_CHECK;
                    busy_nxt   = 1'b1;
`else
                    state_nxt  = ST_IDLE;
                    done_nxt   = 1'b1;
                    frames_nxt = frames_o + 8'd1;
`endif
                end else begin
                    cnt_nxt      = cnt + CW'(1);
                    ser_nxt      = img[LAST - cnt_nxt];
                    shift_en_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                end
            end
            ST_CHECK: begin
                state_nxt = ST_IDLE;
`ifdef SR_LOAD_READBACK_EN
                if (!abort_i) begin
                    done_nxt   = 1'b1;
                    frames_nxt = frames_o + 8'd1;
                    err_nxt    = (sr_i != img);
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counter, held word and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            img        <= '0;
            ser_o      <= 1'b0;
            shift_en_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            frames_o   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            img        <= img_nxt;
            ser_o      <= ser_nxt;
            shift_en_o <= shift_en_nxt;
            busy_o     <= busy_nxt;
            done_o     <= done_nxt;
            frames_o   <= frames_nxt;
        end
    end

`ifdef SR_LOAD_READBACK_EN
    // Readback result register; only meaningful alongside done_o.
    always_ff @(posedge clk) begin
        if (!rstn) err_o <= 1'b0;
        else       err_o <= err_nxt;
    end
`endif

endmodule

// File: tb/tb_sr_load_ctrl.sv
// Testbench for sr_load_ctrl: two instances (MSB-first and LSB-first) share
// the same stimulus, each driving its own behavioural shift register.
module tb_sr_load_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn, req_valid, abort, fault;
    logic [W-1:0] req_data;

    logic         a_ready, a_ser, a_sen, a_busy, a_done, a_err;
    logic         b_ready, b_ser, b_sen, b_busy, b_done, b_err;
    logic [7:0]   a_frames, b_frames;
    logic [W-1:0] sr_a = '0, sr_b = '0;
    logic [W-1:0] a_sr_in, b_sr_in;

    int n_vec = 0;
    int n_err = 0;
    int frames_exp = 0;

    assign a_sr_in = fault ? '0 : sr_a;
    assign b_sr_in = fault ? '0 : sr_b;

    // External serial-in shift registers: shift in at the LSB.
    always @(posedge clk) begin
        if (a_sen) sr_a <= {sr_a[W-2:0], a_ser};
        if (b_sen) sr_b <= {sr_b[W-2:0], b_ser};
    end

    sr_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rstn(rstn), .req_valid_i(req_valid), .req_ready_o(a_ready),
        .req_data_i(req_data), .abort_i(abort), .ser_o(a_ser), .shift_en_o(a_sen),
        .sr_i(a_sr_in), .busy_o(a_busy), .done_o(a_done), .err_o(a_err),
        .frames_o(a_frames)
    );

    sr_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rstn(rstn), .req_valid_i(req_valid), .req_ready_o(b_ready),
        .req_data_i(req_data), .abort_i(abort), .ser_o(b_ser), .shift_en_o(b_sen),
        .sr_i(b_sr_in), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
        .frames_o(b_frames)
    );

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic rdy, input logic sen,
                           input logic bsy, input logic dn, input logic er);
        chk({tag, ".a_ready"},  32'(a_ready),  32'(rdy));
        chk({tag, ".b_ready"},  32'(b_ready),  32'(rdy));
        chk({tag, ".a_sen"},    32'(a_sen),    32'(sen));
        chk({tag, ".b_sen"},    32'(b_sen),    32'(sen));
        chk({tag, ".a_busy"},   32'(a_busy),   32'(bsy));
        chk({tag, ".b_busy"},   32'(b_busy),   32'(bsy));
        chk({tag, ".a_done"},   32'(a_done),   32'(dn));
        chk({tag, ".b_done"},   32'(b_done),   32'(dn));
        chk({tag, ".a_err"},    32'(a_err),    32'(er));
        chk({tag, ".b_err"},    32'(b_err),    32'(er));
        chk({tag, ".a_frames"}, 32'(a_frames), 32'(frames_exp % 256));
        chk({tag, ".b_frames"}, 32'(b_frames), 32'(frames_exp % 256));
    endtask

    // One frame starting in the current (idle) cycle. abort_at / rst_at name
    // the cycle (1..W, or W+1 for the check cycle) whose closing edge sees
    // abort_i / rstn=0; 0 means never.
    task automatic frame(input logic [W-1:0] w, input int abort_at, input int rst_at,
                         input bit flt, input bit hold);
        logic experr;
        chk("accept.a_ready", 32'(a_ready), 32'd1);
        chk("accept.b_ready", 32'(b_ready), 32'd1);
        req_valid = 1'b1;
        req_data  = w;
        tick();
        for (int k = 1; k <= W; k++) begin
            if (!hold) req_valid = 1'b0;
            chk_ctl($sformatf("shift%0d", k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("shift%0d.a_ser", k), 32'(a_ser), 32'((w >> (W - k)) & 1));
            chk($sformatf("shift%0d.b_ser", k), 32'(b_ser), 32'((w >> (k - 1)) & 1));
            if (abort_at == k) begin
                abort = 1'b1;
                req_valid = 1'b0;
                tick();
                abort = 1'b0;
                chk_ctl("abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (rst_at == k) begin
                rstn = 1'b0;
                req_valid = 1'b0;
                tick();
                frames_exp = 0;
                chk_ctl("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("midrst.a_ser", 32'(a_ser), 32'd0);
                chk("midrst.b_ser", 32'(b_ser), 32'd0);
                rstn = 1'b1;
                tick();
                chk_ctl("rst_rel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            tick();
        end
        experr = 1'b0;
`ifdef SR_LOAD_READBACK_EN
        chk_ctl("check", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        if (abort_at == W + 1) begin
            abort = 1'b1;
            req_valid = 1'b0;
            tick();
            abort = 1'b0;
            chk_ctl("abort_chk", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        fault = flt;
        tick();
        fault = 1'b0;
        experr = flt && (w != '0);
`endif
        frames_exp = (frames_exp + 1) % 256;
        chk_ctl("done", 1'b1, 1'b0, 1'b0, 1'b1, experr);
        chk("done.sr_a", 32'(sr_a), 32'(w));
        chk("done.sr_b", 32'(sr_b), 32'(rev(w)));
        if (flt) begin
            tick();
            chk_ctl("err_clr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_data  = '0;
        abort     = 1'b0;
        fault     = 1'b0;

        tick();
        chk_ctl("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst1.a_ser", 32'(a_ser), 32'd0);
        chk("rst1.b_ser", 32'(b_ser), 32'd0);
        tick();
        chk_ctl("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        tick();
        chk_ctl("rel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        frame(4'b1011, 0, 0, 1'b0, 1'b0);
        tick();
        frame(4'b0001, 0, 0, 1'b0, 1'b0);
`ifdef SR_LOAD_READBACK_EN
        frame(4'b0110, 0, 0, 1'b1, 1'b0);
`endif
        frame(4'b1100, 2, 0, 1'b0, 1'b0);
        frame(4'b0101, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            frame(W'($urandom), int'($urandom_range(0, W + 2)), 0, 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        frame(W'($urandom), 0, 3, 1'b0, 1'b0);

        for (int n = 0; n < 256; n++)
            frame(W'($urandom), 0, 0, 1'b0, 1'b1);
        req_valid = 1'b0;
        chk("wrap.a_frames", 32'(a_frames), 32'd0);
        chk("wrap.b_frames", 32'(b_frames), 32'd0);
        tick();
        chk_ctl("final", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
